stop_watch_run_ctl: RTL and testbench
=====================================

Name: stop_watch_run_ctl

Overview:
- Run/stop/lap controller that sequences the stopwatch time base and feeds the display controller.
- Takes single-cycle button strobes and the 100 Hz timing pulse, and keeps the centisecond, second and minute counters.
- Drives the us_cnt/s_cnt/m_cnt/disp_mode inputs of the display control block, with display freeze during lap.
- Sits between the button debouncers and the display control block.

Parameters:
CS_MAX, 99, last centisecond value before wrap (must fit 7 bits)
SEC_MAX, 59, last second value before wrap (must fit 6 bits)
MIN_MAX, 99, last minute value; overflow point (must fit 7 bits)

Ports:
clk  input  1  system clock, 125 MHz
rst  input  1  synchronous reset, active-high
pls_100hz  input  1  100 Hz timing pulse, level high ≥2 clk per period; rising edge = one centisecond
btn_start  input  1  start/stop strobe, 1 clk wide, debounced
btn_lap  input  1  lap/clear strobe, 1 clk wide, debounced
btn_mode  input  1  display-mode toggle strobe, 1 clk wide
us_cnt  output  7  displayed centiseconds 0..CS_MAX
s_cnt  output  6  displayed seconds 0..SEC_MAX
m_cnt  output  7  displayed minutes 0..MIN_MAX
disp_mode  output  1  0 = sec.centisec, 1 = min.sec
running  output  1  1 in RUN or LAP
lap_hold  output  1  1 in LAP (display frozen)
ovf  output  1  sticky overflow flag

Behaviour:
- Reset is synchronous, active-high, and applies on any clk edge with rst=1, including mid-count. Reset values:
  - state=IDLE
  - all live and displayed counters 0
  - disp_mode=0, running=0, lap_hold=0, ovf=0
  - edge-detect regs p0=p1=0
- Tick detect: p0<=pls_100hz, p1<=p0; tick = p0 & ~p1 (combinational, 1 clk wide).
  - pls_100hz sampled high at edge N gives tick during cycle N..N+1.
  - Live counters update at edge N+1.
  - Outputs (when not frozen) update at edge N+2.
- Live counters cs/sec/min:
  - Advance on tick only when the current state is RUN or LAP.
  - cs wraps CS_MAX->0 and carries to sec. sec wraps SEC_MAX->0 and carries to min.
- Overflow: a tick at MIN_MAX:SEC_MAX:CS_MAX does not wrap.
  - Counters hold at max, ovf<=1, state<=STOP.
  - ovf clears only on reset or entry to IDLE.
- States and transitions, evaluated per cycle in this priority order: rst > btn_start > btn_lap.
  - IDLE: btn_start -> RUN. btn_lap ignored.
  - RUN: btn_start -> STOP. btn_lap -> LAP, capturing live counters into the display registers that same edge.
  - LAP: btn_start -> STOP. btn_lap -> RUN. Counting continues; display registers hold the captured value.
  - STOP: btn_start -> RUN, resuming from held count. btn_lap -> IDLE, clearing live and displayed counters and ovf.
- Simultaneous btn_start+btn_lap in one cycle: only btn_start acts.
- Tick coincident with the transition out of RUN/LAP: the tick is counted, because the current state decides.
- Tick coincident with IDLE->RUN or STOP->RUN: the tick is not counted.
- Display registers: in all states except LAP they copy the live counters every cycle, so there is 1 clk lag. On LAP->RUN or LAP->STOP they resume tracking the next edge.
- disp_mode toggles on btn_mode in any state, independent of the state machine and of other buttons in the same cycle.
- running and lap_hold are registered decodes of the next state, valid the same edge the state changes.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then btn_start, then 150 pls_100hz pulses -> running=1; after the last pulse plus 2 clk: s_cnt=1, us_cnt=50, m_cnt=0.
2. In RUN at 0:12.34: btn_lap, 30 pulses, btn_lap -> display holds 12/34 with lap_hold=1 throughout; after release, shows 12/64 with lap_hold=0.
3. btn_start and btn_lap asserted in the same cycle while in RUN -> state STOP, lap_hold=0, running=0. Then btn_lap -> all counts 0, state IDLE.
4. Preload near max, reach 99:59.99, one more pulse -> counts hold 99/59/99, ovf=1, running=0. btn_lap -> counts 0, ovf=0.
5. Tick edge on the same cycle as btn_start in RUN -> count advances by exactly 1. Tick on the same cycle as btn_start in STOP -> no advance.
6. rst pulsed for 1 clk mid-run with disp_mode=1 -> next edge: all counters 0, disp_mode=0, state IDLE. Subsequent pulses leave counts at 0.

Source files
------------

// File: rtl/stop_watch_run_ctl.sv
// Stopwatch run/stop/lap controller: keeps the cs/sec/min time base
// and drives frozen-or-live counts to the display control block.
module stop_watch_run_ctl #(
    parameter int unsigned CS_MAX  = 99,
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pls_100hz,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_mode,
    output logic [6:0] us_cnt,
    output logic [5:0] s_cnt,
    output logic [6:0] m_cnt,
    output logic       disp_mode,
    output logic       running,
    output logic       lap_hold,
    output logic       ovf
);

    localparam logic [6:0] CS_TOP  = 7'(CS_MAX);
    localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
    localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        STOP
    } state_t;

    state_t     state_q, state_d;
    logic       p0_q, p1_q;
    logic       tick;
    logic       clr;
    logic       active;
    logic       at_max;
    logic [6:0] cs_q, cs_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] min_q, min_d;
    logic [6:0] us_q, us_d;
    logic [5:0] s_q, s_d;
    logic [6:0] m_q, m_d;
    logic       mode_q, mode_d;
    logic       run_q, run_d;
    logic       lh_q, lh_d;
    logic       ovf_q, ovf_d;

    assign tick   = p0_q & ~p1_q;
    assign active = (state_q == RUN) || (state_q == LAP);
    assign at_max = (cs_q == CS_TOP) && (sec_q == SEC_TOP) &&
                    (min_q == MIN_TOP);

    // Next state, time base advance/overflow and display capture
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        cs_d    = cs_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (btn_start) state_d = RUN;
            RUN: begin
                if (btn_start)    state_d = STOP;
                else if (btn_lap) state_d = LAP;
            end
            LAP: begin
                if (btn_start)    state_d = STOP;
                else if (btn_lap) state_d = RUN;
            end
            STOP: begin
                if (btn_start) begin
                    state_d = RUN;
                end else if (btn_lap) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tick && active) begin
            if (at_max) begin
                ovf_d   = 1'b1;
                state_d = STOP;
            end else if (cs_q == CS_TOP) begin
                cs_d = 7'd0;
                if (sec_q == SEC_TOP) begin
                    sec_d = 6'd0;
                    min_d = min_q + 7'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end
        us_d = (state_q == LAP) ? us_q : cs_q;
        s_d  = (state_q == LAP) ? s_q  : sec_q;
        m_d  = (state_q == LAP) ? m_q  : min_q;
        if (clr) begin
            cs_d  = 7'd0;
            sec_d = 6'd0;
            min_d = 7'd0;
            us_d  = 7'd0;
            s_d   = 6'd0;
            m_d   = 7'd0;
            ovf_d = 1'b0;
        end
        mode_d = mode_q ^ btn_mode;
        run_d  = (state_d == RUN) || (state_d == LAP);
        lh_d   = (state_d == LAP);
    end

    // Register all state, counters and outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p0_q    <= 1'b0;
            p1_q    <= 1'b0;
            cs_q    <= 7'd0;
            sec_q   <= 6'd0;
            min_q   <= 7'd0;
            us_q    <= 7'd0;
            s_q     <= 6'd0;
            m_q     <= 7'd0;
            mode_q  <= 1'b0;
            run_q   <= 1'b0;
            lh_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p0_q    <= pls_100hz;
            p1_q    <= p0_q;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            us_q    <= us_d;
            s_q     <= s_d;
            m_q     <= m_d;
            mode_q  <= mode_d;
            run_q   <= run_d;
            lh_q    <= lh_d;
            ovf_q   <= ovf_d;
        end
    end

    assign us_cnt    = us_q;
    assign s_cnt     = s_q;
    assign m_cnt     = m_q;
    assign disp_mode = mode_q;
    assign running   = run_q;
    assign lap_hold  = lh_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stop_watch_run_ctl.sv
// Bench for stop_watch_run_ctl: default-size and reduced-size instances
// checked against a total-centisecond reference model.
module tb_stop_watch_run_ctl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    typedef struct {
        int st;
        int t;
        int dt;
        bit ovf;
        bit mode;
        bit p0;
        bit p1;
        bit run;
        bit lh;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pls = 1'b0;
    logic btn_start = 1'b0;
    logic btn_lap = 1'b0;
    logic btn_mode = 1'b0;

    logic [6:0] us_b, m_b, us_s, m_s;
    logic [5:0] s_b, s_s;
    logic md_b, run_b, lh_b, ovf_b;
    logic md_s, run_s, lh_s, ovf_s;
    logic [23:0] obs_b, obs_s;

    int n_vec = 0;
    int n_err = 0;
    mdl_t mb = '{default: 0};
    mdl_t ms = '{default: 0};

    assign obs_b = {us_b, s_b, m_b, md_b, run_b, lh_b, ovf_b};
    assign obs_s = {us_s, s_s, m_s, md_s, run_s, lh_s, ovf_s};

    always #4 clk = ~clk;

    stop_watch_run_ctl dut (
        .clk(clk), .rst(rst), .pls_100hz(pls),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_mode(btn_mode),
        .us_cnt(us_b), .s_cnt(s_b), .m_cnt(m_b), .disp_mode(md_b),
        .running(run_b), .lap_hold(lh_b), .ovf(ovf_b)
    );

    stop_watch_run_ctl #(.CS_MAX(3), .SEC_MAX(2), .MIN_MAX(1)) dut_s (
        .clk(clk), .rst(rst), .pls_100hz(pls),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_mode(btn_mode),
        .us_cnt(us_s), .s_cnt(s_s), .m_cnt(m_s), .disp_mode(md_s),
        .running(run_s), .lap_hold(lh_s), .ovf(ovf_s)
    );

    function automatic mdl_t step(mdl_t m, int tmax, bit r, bit st,
                                  bit lp, bit md, bit pl);
        mdl_t n;
        bit tk;
        bit act;
        bit clr;
        int ns;
        n = m;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        tk = m.p0 && !m.p1;
        n.p1 = m.p0;
        n.p0 = pl;
        act = (m.st == M_RUN) || (m.st == M_LAP);
        ns = m.st;
        clr = 1'b0;
        if (st) begin
            ns = act ? M_STOP : M_RUN;
        end else if (lp) begin
            if (m.st == M_RUN) ns = M_LAP;
            else if (m.st == M_LAP) ns = M_RUN;
            else if (m.st == M_STOP) begin
                ns = M_IDLE;
                clr = 1'b1;
            end
        end
        if (tk && act) begin
            if (m.t == tmax) begin
                n.ovf = 1'b1;
                ns = M_STOP;
            end else begin
                n.t = m.t + 1;
            end
        end
        if (m.st != M_LAP) n.dt = m.t;
        if (clr) begin
            n.t = 0;
            n.dt = 0;
            n.ovf = 1'b0;
        end
        n.mode = m.mode ^ md;
        n.st = ns;
        n.run = (ns == M_RUN) || (ns == M_LAP);
        n.lh = (ns == M_LAP);
        return n;
    endfunction

    function automatic logic [23:0] exp_vec(mdl_t m, int cs, int sc);
        int cm;
        int sm;
        cm = cs + 1;
        sm = sc + 1;
        return {7'(m.dt % cm), 6'((m.dt / cm) % sm), 7'(m.dt / (cm * sm)),
                m.mode, m.run, m.lh, m.ovf};
    endfunction

    task automatic cyc();
        mb = step(mb, 100 * 60 * 100 - 1, rst, btn_start, btn_lap,
                  btn_mode, pls);
        ms = step(ms, 2 * 3 * 4 - 1, rst, btn_start, btn_lap,
                  btn_mode, pls);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            pls = 1'b1;
            repeat (2 + $urandom % 2) cyc();
            pls = 1'b0;
            repeat (2 + $urandom % 2) cyc();
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1;
        cyc();
        btn_lap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs_b !== 24'd0) begin
            n_err++;
            $display("FAIL reset_big got %h exp %h", obs_b, 24'd0);
        end
        n_vec++;
        if (obs_s !== 24'd0) begin
            n_err++;
            $display("FAIL reset_small got %h exp %h", obs_s, 24'd0);
        end
    endtask

    task automatic test_count();
        press_start();
        n_vec++;
        if ({run_b, lh_b} !== 2'b10) begin
            n_err++;
            $display("FAIL start_run got %b%b exp 10", run_b, lh_b);
        end
        pulses(150);
        n_vec++;
        if ({m_b, s_b, us_b, run_b} !== {7'd0, 6'd1, 7'd50, 1'b1}) begin
            n_err++;
            $display("FAIL count150 got %0d:%0d.%0d run %b exp 0:1.50 run 1",
                     m_b, s_b, us_b, run_b);
        end
        n_vec++;
        if (obs_s !== exp_vec(ms, 3, 2)) begin
            n_err++;
            $display("FAIL count150_small got %h exp %h",
                     obs_s, exp_vec(ms, 3, 2));
        end
    endtask

    task automatic test_lap();
        do_reset();
        press_start();
        pulses(1234);
        n_vec++;
        if ({s_b, us_b} !== {6'd12, 7'd34}) begin
            n_err++;
            $display("FAIL pre_lap got %0d.%0d exp 12.34", s_b, us_b);
        end
        press_lap();
        n_vec++;
        if ({run_b, lh_b} !== 2'b11) begin
            n_err++;
            $display("FAIL lap_enter got %b%b exp 11", run_b, lh_b);
        end
        for (int i = 0; i < 30; i++) begin
            pulses(1);
            n_vec++;
            if ({s_b, us_b, lh_b} !== {6'd12, 7'd34, 1'b1}) begin
                n_err++;
                $display("FAIL lap_hold got %0d.%0d lh %b exp 12.34 lh 1",
                         s_b, us_b, lh_b);
            end
        end
        press_lap();
        cyc();
        n_vec++;
        if ({s_b, us_b, lh_b, run_b} !== {6'd12, 7'd64, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL lap_release got %0d.%0d lh %b run %b exp 12.64 0 1",
                     s_b, us_b, lh_b, run_b);
        end
        n_vec++;
        if (obs_b !== exp_vec(mb, 99, 59)) begin
            n_err++;
            $display("FAIL lap_model got %h exp %h", obs_b, exp_vec(mb, 99, 59));
        end
    endtask

    task automatic test_simultaneous();
        btn_start = 1'b1;
        btn_lap = 1'b1;
        cyc();
        btn_start = 1'b0;
        btn_lap = 1'b0;
        n_vec++;
        if ({run_b, lh_b} !== 2'b00) begin
            n_err++;
            $display("FAIL both_btn got run %b lh %b exp 0 0", run_b, lh_b);
        end
        cyc();
        n_vec++;
        if ({s_b, us_b} !== {6'd12, 7'd64}) begin
            n_err++;
            $display("FAIL stop_hold got %0d.%0d exp 12.64", s_b, us_b);
        end
        press_lap();
        n_vec++;
        if (obs_b !== 24'd0) begin
            n_err++;
            $display("FAIL clear_idle got %h exp %h", obs_b, 24'd0);
        end
        pulses(3);
        n_vec++;
        if (obs_b !== exp_vec(mb, 99, 59)) begin
            n_err++;
            $display("FAIL idle_no_count got %h exp %h",
                     obs_b, exp_vec(mb, 99, 59));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        press_start();
        pulses(23);
        n_vec++;
        if ({m_s, s_s, us_s, ovf_s} !== {7'd1, 6'd2, 7'd3, 1'b0}) begin
            n_err++;
            $display("FAIL at_max got %0d:%0d.%0d ovf %b exp 1:2.3 ovf 0",
                     m_s, s_s, us_s, ovf_s);
        end
        pulses(1);
        n_vec++;
        if ({m_s, s_s, us_s, ovf_s, run_s} !==
            {7'd1, 6'd2, 7'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ovf got %0d:%0d.%0d ovf %b run %b exp 1:2.3 1 0",
                     m_s, s_s, us_s, ovf_s, run_s);
        end
        pulses(2);
        n_vec++;
        if (obs_s !== exp_vec(ms, 3, 2)) begin
            n_err++;
            $display("FAIL ovf_hold got %h exp %h", obs_s, exp_vec(ms, 3, 2));
        end
        press_lap();
        n_vec++;
        if (obs_s !== 24'd0) begin
            n_err++;
            $display("FAIL ovf_clear got %h exp %h", obs_s, 24'd0);
        end
    endtask

    task automatic test_tick_edge();
        do_reset();
        press_start();
        pulses(5);
        pls = 1'b1;
        cyc();
        press_start();
        pls = 1'b0;
        cyc();
        cyc();
        n_vec++;
        if ({us_b, run_b} !== {7'd6, 1'b0}) begin
            n_err++;
            $display("FAIL tick_stop got us %0d run %b exp 6 0", us_b, run_b);
        end
        pls = 1'b1;
        cyc();
        press_start();
        pls = 1'b0;
        cyc();
        cyc();
        n_vec++;
        if ({us_b, run_b} !== {7'd6, 1'b1}) begin
            n_err++;
            $display("FAIL tick_resume got us %0d run %b exp 6 1", us_b, run_b);
        end
    endtask

    task automatic test_reset_mid();
        btn_mode = 1'b1;
        cyc();
        btn_mode = 1'b0;
        pulses(3);
        n_vec++;
        if ({md_b, run_b, us_b} !== {1'b1, 1'b1, 7'd9}) begin
            n_err++;
            $display("FAIL mode_run got md %b run %b us %0d exp 1 1 9",
                     md_b, run_b, us_b);
        end
        do_reset();
        n_vec++;
        if (obs_b !== 24'd0) begin
            n_err++;
            $display("FAIL reset_mid got %h exp %h", obs_b, 24'd0);
        end
        pulses(5);
        n_vec++;
        if (obs_b !== 24'd0) begin
            n_err++;
            $display("FAIL post_reset got %h exp %h", obs_b, 24'd0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 3 == 0) pls = ~pls;
            rst = ($urandom % 400 == 0);
            btn_start = !btn_start && ($urandom % 12 == 0);
            btn_lap = !btn_lap && ($urandom % 8 == 0);
            btn_mode = !btn_mode && ($urandom % 16 == 0);
            cyc();
            n_vec++;
            if (obs_b !== exp_vec(mb, 99, 59)) begin
                n_err++;
                $display("FAIL rand_big cyc %0d got %h exp %h",
                         i, obs_b, exp_vec(mb, 99, 59));
            end
            n_vec++;
            if (obs_s !== exp_vec(ms, 3, 2)) begin
                n_err++;
                $display("FAIL rand_small cyc %0d got %h exp %h",
                         i, obs_s, exp_vec(ms, 3, 2));
            end
        end
        rst = 1'b0;
        btn_start = 1'b0;
        btn_lap = 1'b0;
        btn_mode = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count();
        test_lap();
        test_simultaneous();
        test_overflow();
        test_tick_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
